// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and FSM state type for the Booth multiplier
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int RES_W  = 16;
  localparam int N_ITER = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth add/subtract and arithmetic shift
module booth_step
  import mult_pkg::*;
(
  input  logic [OP_W:0]   a_i,
  input  logic [OP_W-1:0] q_i,
  input  logic            q1_i,
  input  logic [OP_W-1:0] m_i,
  output logic [OP_W:0]   a_o,
  output logic [OP_W-1:0] q_o,
  output logic            q1_o
);

  logic [OP_W:0] m_ext;
  logic [OP_W:0] sum;

  // A is one bit wider than M so that subtracting M = -128 cannot overflow
  assign m_ext = {m_i[OP_W-1], m_i};

  always_comb begin
    sum = a_i;
    case ({q_i[0], q1_i})
      2'b01:   sum = a_i + m_ext;
      2'b10:   sum = a_i - m_ext;
      default: sum = a_i;
    endcase
  end

  assign a_o  = {sum[OP_W], sum[OP_W:1]};
  assign q_o  = {sum[0], q_i[OP_W-1:1]};
  assign q1_o = q_i[0];

endmodule

// File: rtl/mult_booth_ctrl.sv
// rtl/mult_booth_ctrl.sv - sequential 8x8 signed Booth multiplier; MULT_ABORT_EN adds an abort input
module mult_booth_ctrl
  import mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [OP_W-1:0]  multiplicando,
  input  logic signed [OP_W-1:0]  multiplicador,
`ifdef MULT_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy,
  output logic                    done,
  output logic signed [RES_W-1:0] resultado,
  output logic [2:0]              contador
);

  localparam logic [2:0] LAST_CNT = 3'(N_ITER - 1);

  state_t            state_q, state_d;
  logic [OP_W:0]     a_q, a_d;
  logic [OP_W-1:0]   q_q, q_d;
  logic              q1_q, q1_d;
  logic [OP_W-1:0]   m_q, m_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic [OP_W:0]     step_a;
  logic [OP_W-1:0]   step_q;
  logic              step_q1;

  booth_step u_booth_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a),
    .q_o  (step_q),
    .q1_o (step_q1)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicando;
          q_d     = multiplicador;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef MULT_ABORT_EN
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else
`endif
        begin
          a_d  = step_a;
          q_d  = step_q;
          q1_d = step_q1;
          // The result register only ever sees the completed product
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
            res_d   = {step_a[OP_W-1:0], step_q};
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign contador  = cnt_q;
  assign resultado = res_q;

endmodule

// File: doc/mult_booth_ctrl.md
MULT_BOOTH_CTRL -- requirements
Module: mult_booth_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a multiplication; sampled on the clk edge.
REQ-004 SHALL have port multiplicando, input, 8 bits, signed: operand M, captured when start is accepted.
REQ-005 SHALL have port multiplicador, input, 8 bits, signed: operand Q, captured when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-008 SHALL have port resultado, output, 16 bits, signed: product M*Q.
REQ-009 SHALL have port contador, output, 3 bits: current iteration index, 0..7.

Function
REQ-010 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-011 SHALL treat start as accepted only in IDLE: capture operands, clear A (9 bits) and q_1, set contador=0, go to CALC.
REQ-012 SHALL ignore start in CALC or DONE, with no effect on operands or state.
REQ-013 SHALL perform one radix-2 Booth step per CALC cycle, selected by the pair {Q[0],q_1}.
REQ-014 SHALL apply the step as: 01 -> A+=sext(M); 10 -> A-=sext(M); 00/11 -> no add; then shift {A,Q,q_1} arithmetic right by 1.
REQ-015 SHALL hold A at 9 bits so that M=-128 never overflows; resultado={A,Q}[15:0] after the final step.
REQ-016 SHALL increment contador each CALC step; the step taken with contador==7 is the last, and the FSM goes to DONE.
REQ-017 SHALL have a latency of 8 cycles: start accepted at edge k gives done=1 in the cycle after edge k+8.
REQ-018 SHALL go from DONE to IDLE unconditionally after one cycle; done is high only in DONE.
REQ-019 SHALL hold resultado stable from DONE until the next accepted start; it updates only at the end of CALC, never with partial products.
REQ-020 SHALL have busy=1 exactly in CALC and contador=0 outside CALC.

Reset
REQ-021 SHALL, while rst=1 at an edge, force state=IDLE, resultado=0, done=0, busy=0, contador=0, and clear A, Q, q_1 and M.
REQ-022 SHALL abandon an operation when rst is asserted mid-CALC or in DONE: no done pulse, resultado=0.
REQ-023 SHALL give rst priority over start on the same edge.

Configuration
REQ-024 SHALL, with MULT_ABORT_EN defined, add input abort (1 bit).
REQ-025 SHALL, with MULT_ABORT_EN defined, make abort=1 in CALC return the FSM to IDLE next edge with contador=0, no done pulse and resultado unchanged.
REQ-026 SHALL, with MULT_ABORT_EN defined, ignore abort outside CALC and give abort priority over a final step on the same edge.
REQ-027 SHALL, without MULT_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-028 SHALL place in package mult_pkg: constants OP_W=8, RES_W=16, N_ITER=8, and typedef enum state_t {IDLE, CALC, DONE}.
REQ-029 SHALL use one combinational sub-module booth_step (inputs A, Q, q_1, M; outputs next A, Q, q_1) instantiated once; the FSM and registers stay in mult_booth_ctrl.

Verification
REQ-030 SHALL test basic multiply: M=3, Q=5, start pulse -> done exactly 8 cycles after acceptance, resultado=16'h000F.
REQ-031 SHALL test extreme operands: M=-128, Q=-128 -> resultado=16'h4000; M=-128, Q=127 -> resultado=16'hC080; M=0, Q=-1 -> 16'h0000.
REQ-032 SHALL test busy rejection: start held high with new operands during CALC -> first result unaffected, one done pulse, then IDLE; with start still high in IDLE, a new operation is accepted.
REQ-033 SHALL test reset mid-operation: rst at contador=4 -> next cycle state IDLE, resultado=0, no done pulse; a later M=-7, Q=9 -> 16'hFFC1.
REQ-034 SHALL test abort with MULT_ABORT_EN: after a completed 2*3 (16'h0006), start 10*10 and abort at contador=3 -> no done, resultado stays 16'h0006, busy=0 next cycle.
REQ-035 SHALL run a 500-operation random regression comparing against a $signed reference model; check done width=1 and busy==(state==CALC) every cycle.
